// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the DAC fast-write link: target FSM states,
// bus address and fast-write field layout, used by controller and target alike.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK,
    ST_HI,
    ST_LO,
    ST_IGNORE
  } i2c_state_t;

  localparam logic [6:0] DAC_I2C_ADDR      = 7'b1100000;
  localparam logic [1:0] FW_CMD_FAST_WRITE = 2'b00;
  localparam int         FW_CMD_MSB        = 7;
  localparam int         FW_CMD_LSB        = 6;
  localparam int         FW_PD_MSB         = 5;
  localparam int         FW_PD_LSB         = 4;

  // Offset-binary code to two's complement is just an MSB flip.
  function automatic logic [11:0] fw_decode(input logic [7:0] hi,
                                            input logic [7:0] lo,
                                            input logic       signed_out);
    logic [11:0] v;
    v = {hi[3:0], lo};
    if (signed_out) v[11] = ~v[11];
    return v;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk domain and derives edge and START/STOP pulses.
// Pulses are one clk wide and aligned with the synchronised line levels.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_prev <= r_scl_sync[1];
      r_sda_prev <= r_sda_sync[1];
    end
  end

  logic w_scl;
  logic w_sda;
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  // SCL must be high both before and after, so an SDA move racing SCL is not a START/STOP.
  assign o_start    = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
  assign o_stop     = r_scl_prev & w_scl & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_dac_target.sv
// I2C write-only target decoding DAC fast-write frames ({hi,lo} pairs) into
// 12-bit samples; ACKs by pulling SDA low, never stretches SCL.
module i2c_dac_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = DAC_I2C_ADDR,
  parameter bit         SIGNED_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic [11:0] sample,
  output logic [1:0]  pd,
  output logic        sample_valid,
  output logic        cmd_error,
  output logic        busy
);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  i2c_line_sync u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .i_scl      (i2c_scl),
    .i_sda      (i2c_sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_state_t  r_state;
  i2c_state_t  r_ret_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_hi;
  logic        r_ack_phase;
  logic        r_sda_drive;
  logic [11:0] r_sample;
  logic [1:0]  r_pd;
  logic        r_sample_valid;
  logic        r_cmd_error;
  logic        r_busy;

  logic [7:0] w_byte;
  logic       w_byte_done;
  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_byte_done = w_scl_rise && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ret_state    <= ST_IDLE;
      r_bit_cnt      <= 3'd0;
      r_shift        <= 8'd0;
      r_hi           <= 8'd0;
      r_ack_phase    <= 1'b0;
      r_sda_drive    <= 1'b0;
      r_sample       <= 12'd0;
      r_pd           <= 2'd0;
      r_sample_valid <= 1'b0;
      r_cmd_error    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_cmd_error    <= 1'b0;
      if (w_start) begin
        r_state     <= ST_ADDR;
        r_bit_cnt   <= 3'd0;
        r_ack_phase <= 1'b0;
        r_sda_drive <= 1'b0;
        r_busy      <= 1'b0;
      end else if (w_stop) begin
        r_state     <= ST_IDLE;
        r_bit_cnt   <= 3'd0;
        r_ack_phase <= 1'b0;
        r_sda_drive <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_HI, ST_LO: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              if (r_state == ST_ADDR) begin
                if (w_byte[7:1] == I2C_ADDR && !w_byte[0]) begin
                  r_state     <= ST_ACK;
                  r_ret_state <= ST_HI;
                  r_busy      <= 1'b1;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end else if (r_state == ST_HI) begin
                if (w_byte[FW_CMD_MSB:FW_CMD_LSB] == FW_CMD_FAST_WRITE) begin
                  r_hi        <= w_byte;
                  r_state     <= ST_ACK;
                  r_ret_state <= ST_LO;
                end else begin
                  r_cmd_error <= 1'b1;
                  r_state     <= ST_IGNORE;
                end
              end else begin
                r_sample       <= fw_decode(r_hi, w_byte, SIGNED_OUT);
                r_pd           <= r_hi[FW_PD_MSB:FW_PD_LSB];
                r_sample_valid <= 1'b1;
                r_state        <= ST_ACK;
                r_ret_state    <= ST_HI;
              end
            end
          end
          // First SCL fall opens the ACK slot, second one closes it.
          ST_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_drive <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_drive <= 1'b0;
                r_ack_phase <= 1'b0;
                r_bit_cnt   <= 3'd0;
                r_state     <= r_ret_state;
              end
            end
          end
          default: begin
            r_sda_drive <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_sda      = r_sda_drive ? 1'b0 : 1'bz;
  assign sample       = r_sample;
  assign pd           = r_pd;
  assign sample_valid = r_sample_valid;
  assign cmd_error    = r_cmd_error;
  assign busy         = r_busy;

endmodule

// File: tb/tb_i2c_dac_target.sv
// Bench for i2c_dac_target: bit-banged I2C controller, two targets (signed and
// raw decode) on one bus, scoreboard of expected samples against captured ones.
module tb_i2c_dac_target;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  i2c_sda;

  assign i2c_sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (i2c_sda);

  always #5 clk = ~clk;

  logic [11:0] sample, sample_raw;
  logic [1:0]  pd, pd_raw;
  logic        sample_valid, sample_valid_raw;
  logic        cmd_error, cmd_error_raw;
  logic        busy, busy_raw;

  i2c_dac_target u_dut (
    .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(i2c_sda),
    .sample(sample), .pd(pd), .sample_valid(sample_valid),
    .cmd_error(cmd_error), .busy(busy)
  );

  i2c_dac_target #(.SIGNED_OUT(1'b0)) u_dut_raw (
    .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(i2c_sda),
    .sample(sample_raw), .pd(pd_raw), .sample_valid(sample_valid_raw),
    .cmd_error(cmd_error_raw), .busy(busy_raw)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] exp_q[$], exp_raw_q[$], got_q[$], got_raw_q[$];
  int n_valid = 0, n_cmd_err = 0, n_busy = 0, n_sda_low = 0;

  always @(negedge clk) begin
    if (sample_valid) begin
      got_q.push_back({pd, sample});
      n_valid++;
    end
    if (sample_valid_raw) got_raw_q.push_back({pd_raw, sample_raw});
    if (cmd_error) n_cmd_err++;
    if (busy) n_busy++;
    if (i2c_sda === 1'b0 && !m_sda_low) n_sda_low++;
  end

  task automatic q_wait();
    repeat (10) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; q_wait();
    scl = 1'b1;       q_wait();
    m_sda_low = 1'b1; q_wait();
    scl = 1'b0;       q_wait();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; q_wait();
    scl = 1'b1;       q_wait();
    m_sda_low = 1'b0; q_wait();
    q_wait();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i]; q_wait();
      scl = 1'b1;        q_wait(); q_wait();
      scl = 1'b0;        q_wait();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    send_bits(b);
    m_sda_low = 1'b0; q_wait();
    scl = 1'b1;       q_wait();
    acked = (i2c_sda === 1'b0);
    q_wait();
    scl = 1'b0;       q_wait();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (sample !== 12'd0) begin n_errors++; $display("FAIL reset_sample got=%h want=000", sample); end
    n_checks++; if (pd !== 2'd0) begin n_errors++; $display("FAIL reset_pd got=%b want=00", pd); end
    n_checks++; if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b want=0", sample_valid); end
    n_checks++; if (cmd_error !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_error got=%b want=0", cmd_error); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (i2c_sda !== 1'b1) begin n_errors++; $display("FAIL reset_sda got=%b want=1", i2c_sda); end
    reset = 1'b0;
    q_wait();
    $display("test_reset: done");
  endtask

  task automatic test_single_pair();
    logic a0, a1, a2;
    int v0;
    v0 = n_valid;
    i2c_start();
    write_byte(8'hC0, a0);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_on got=%b want=1", busy); end
    write_byte(8'h09, a1);
    write_byte(8'h23, a2);
    exp_q.push_back({2'b00, 12'h123});
    exp_raw_q.push_back({2'b00, 12'h923});
    i2c_stop();
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_errors++; $display("FAIL single_acks got=%b want=111", {a0, a1, a2}); end
    n_checks++; if (n_valid - v0 != 1) begin n_errors++; $display("FAIL single_valid_count got=%0d want=1", n_valid - v0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_off got=%b want=0", busy); end
    $display("test_single_pair: acks=%b samples=%0d", {a0, a1, a2}, n_valid - v0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] acks;
    logic a;
    int v0;
    v0 = n_valid;
    i2c_start();
    write_byte(8'hC0, a); acks[4] = a;
    write_byte(8'h00, a); acks[3] = a;
    write_byte(8'h00, a); acks[2] = a;
    exp_q.push_back({2'b00, 12'h800});
    exp_raw_q.push_back({2'b00, 12'h000});
    write_byte(8'h0F, a); acks[1] = a;
    write_byte(8'hFF, a); acks[0] = a;
    exp_q.push_back({2'b00, 12'h7FF});
    exp_raw_q.push_back({2'b00, 12'hFFF});
    i2c_stop();
    n_checks++; if (acks !== 5'b11111) begin n_errors++; $display("FAIL b2b_acks got=%b want=11111", acks); end
    n_checks++; if (n_valid - v0 != 2) begin n_errors++; $display("FAIL b2b_valid_count got=%0d want=2", n_valid - v0); end
    $display("test_back_to_back: acks=%b samples=%0d", acks, n_valid - v0);
  endtask

  task automatic test_not_addressed();
    logic a0, a1, a2, a3;
    int v0, b0, s0;
    v0 = n_valid; b0 = n_busy; s0 = n_sda_low;
    i2c_start();
    write_byte(8'hC2, a0);
    write_byte(8'h09, a1);
    write_byte(8'h23, a2);
    i2c_stop();
    i2c_start();
    write_byte(8'hC1, a3);
    i2c_stop();
    n_checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_errors++; $display("FAIL noaddr_acks got=%b want=0000", {a0, a1, a2, a3}); end
    n_checks++; if (n_sda_low != s0) begin n_errors++; $display("FAIL noaddr_sda_driven got=%0d want=0", n_sda_low - s0); end
    n_checks++; if (n_valid != v0) begin n_errors++; $display("FAIL noaddr_valid got=%0d want=0", n_valid - v0); end
    n_checks++; if (n_busy != b0) begin n_errors++; $display("FAIL noaddr_busy got=%0d want=0", n_busy - b0); end
    $display("test_not_addressed: acks=%b", {a0, a1, a2, a3});
  endtask

  task automatic test_cmd_error();
    logic a0, a1, a2, a3;
    int v0, c0;
    v0 = n_valid; c0 = n_cmd_err;
    i2c_start();
    write_byte(8'hC0, a0);
    write_byte(8'h49, a1);
    write_byte(8'h09, a2);
    write_byte(8'h23, a3);
    i2c_stop();
    n_checks++; if ({a0, a1, a2, a3} !== 4'b1000) begin n_errors++; $display("FAIL cmderr_acks got=%b want=1000", {a0, a1, a2, a3}); end
    n_checks++; if (n_cmd_err - c0 != 1) begin n_errors++; $display("FAIL cmderr_pulses got=%0d want=1", n_cmd_err - c0); end
    n_checks++; if (n_valid != v0) begin n_errors++; $display("FAIL cmderr_valid got=%0d want=0", n_valid - v0); end
    $display("test_cmd_error: acks=%b", {a0, a1, a2, a3});
  endtask

  task automatic test_half_pair();
    logic a0, a1, a2, a3, a4;
    int v0;
    v0 = n_valid;
    i2c_start();
    write_byte(8'hC0, a0);
    write_byte(8'h09, a1);
    i2c_stop();
    n_checks++; if (n_valid != v0) begin n_errors++; $display("FAIL half_discard got=%0d want=0", n_valid - v0); end
    i2c_start();
    write_byte(8'hC0, a2);
    write_byte(8'h31, a3);
    write_byte(8'h55, a4);
    exp_q.push_back({2'b11, 12'h955});
    exp_raw_q.push_back({2'b11, 12'h155});
    i2c_stop();
    n_checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin n_errors++; $display("FAIL half_acks got=%b want=11111", {a0, a1, a2, a3, a4}); end
    n_checks++; if (n_valid - v0 != 1) begin n_errors++; $display("FAIL half_valid got=%0d want=1", n_valid - v0); end
    n_checks++; if (pd !== 2'b11) begin n_errors++; $display("FAIL half_pd got=%b want=11", pd); end
    $display("test_half_pair: samples=%0d pd=%b", n_valid - v0, pd);
  endtask

  task automatic test_reset_mid_ack();
    logic a, a_after;
    int v0, wait_clks;
    i2c_start();
    write_byte(8'hC0, a);
    write_byte(8'h09, a);
    write_byte(8'h23, a);
    exp_q.push_back({2'b00, 12'h123});
    exp_raw_q.push_back({2'b00, 12'h923});
    send_bits(8'h09);
    m_sda_low = 1'b0;
    wait_clks = 0;
    while (i2c_sda !== 1'b0 && wait_clks < 40) begin
      @(posedge clk);
      wait_clks++;
    end
    n_checks++; if (i2c_sda !== 1'b0) begin n_errors++; $display("FAIL rstack_ack_seen got=%b want=0", i2c_sda); end
    @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (i2c_sda !== 1'b1) begin n_errors++; $display("FAIL rstack_sda_release got=%b want=1", i2c_sda); end
    n_checks++; if (sample !== 12'd0) begin n_errors++; $display("FAIL rstack_sample got=%h want=000", sample); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstack_busy got=%b want=0", busy); end
    reset = 1'b0;
    v0 = n_valid;
    q_wait();
    scl = 1'b1; q_wait(); q_wait();
    scl = 1'b0; q_wait();
    write_byte(8'h23, a_after);
    i2c_stop();
    n_checks++; if (a_after !== 1'b0) begin n_errors++; $display("FAIL rstack_ignored_ack got=%b want=0", a_after); end
    n_checks++; if (n_valid != v0) begin n_errors++; $display("FAIL rstack_ignored_valid got=%0d want=0", n_valid - v0); end
    i2c_start();
    write_byte(8'hC0, a);
    write_byte(8'h31, a);
    write_byte(8'h55, a);
    exp_q.push_back({2'b11, 12'h955});
    exp_raw_q.push_back({2'b11, 12'h155});
    i2c_stop();
    n_checks++; if (n_valid - v0 != 1) begin n_errors++; $display("FAIL rstack_recover got=%0d want=1", n_valid - v0); end
    $display("test_reset_mid_ack: recovered samples=%0d", n_valid - v0);
  endtask

  task automatic test_scoreboard();
    logic [13:0] e, g;
    n_checks++; if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL sb_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    n_checks++; if (got_raw_q.size() != exp_raw_q.size()) begin n_errors++; $display("FAIL sb_raw_count got=%0d want=%0d", got_raw_q.size(), exp_raw_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL sb_signed got pd=%b s=%h want pd=%b s=%h", g[13:12], g[11:0], e[13:12], e[11:0]); end
      else $display("sample signed: pd=%b s=%h", g[13:12], g[11:0]);
    end
    while (exp_raw_q.size() > 0 && got_raw_q.size() > 0) begin
      e = exp_raw_q.pop_front(); g = got_raw_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL sb_raw got pd=%b s=%h want pd=%b s=%h", g[13:12], g[11:0], e[13:12], e[11:0]); end
      else $display("sample raw: pd=%b s=%h", g[13:12], g[11:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_not_addressed();
    test_cmd_error();
    test_half_pair();
    test_reset_mid_ack();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
